// File: rtl/hpdcache_pkg.sv
// Shared types for the hpdcache weighted round-robin arbiter.
//   hpdcache_wrr_arb_st_e : arbiter grant FSM state
//     IDLE - grant follows the combinational pick
//     HOLD - grant frozen while the resource stalls
//     LOCK - grant frozen across a multi-beat burst (burst-lock builds only)
package hpdcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        LOCK
    } hpdcache_wrr_arb_st_e;

endpackage

// File: rtl/hpdcache_rr_pick.sv
// Rotating-priority one-hot picker.
// Returns the first set bit of vec_i at or after ptr_i, wrapping N-1 -> 0.
// The vector is doubled, the lower copy is masked below the pointer, and a
// fixed-priority (lowest index) select is folded back modulo N.
//   vec_i    in  N      candidate vector
//   ptr_i    in  IW     priority pointer (highest-priority index)
//   onehot_o out N      one-hot0 selection
module hpdcache_rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o
);

    logic [2*N-1:0] dbl;
    logic           found;

    always_comb begin
        dbl = {vec_i, vec_i};
        for (int j = 0; j < N; j++) begin
            if (j < int'(ptr_i)) dbl[j] = 1'b0;
        end

        onehot_o = '0;
        found    = 1'b0;
        for (int j = 0; j < 2*N; j++) begin
            if (dbl[j] && !found) begin
                onehot_o[j % N] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpdcache_wrr_arb.sv
// Weighted round-robin arbiter for one shared downstream resource.
// Each requester spends one credit per completed transfer; when no active
// requester has credit left, every credit is reloaded from weight_i (0 -> 1)
// in the same cycle, so there is no bubble at refill. The grant is frozen
// while ready_i is low.
// Optional build macro: HPDCACHE_WRR_ARB_BURST_LOCK_EN adds last_i and the
// LOCK state, keeping the grant on the winner until the last beat.
//   clk_i        in   1      clock
//   rst_i        in   1      asynchronous active-high reset
//   req_i        in   N      request vector
//   weight_i     in   N*WW   per-requester weight, slice i = [i*WW +: WW]
//   ready_i      in   1      resource accepts the granted request
//   last_i       in   1      last beat (burst-lock builds only)
//   gnt_o        out  N      one-hot0 grant
//   gnt_valid_o  out  1      |gnt_o
//   gnt_id_o     out  IW     binary index of gnt_o, 0 when no grant
module hpdcache_wrr_arb
    import hpdcache_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned WW = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic [N*WW-1:0] weight_i,
    input  logic            ready_i,
`ifdef HPDCACHE_WRR_ARB_BURST_LOCK_EN
    input  logic            last_i,
`endif
    output logic [N-1:0]    gnt_o,
    output logic            gnt_valid_o,
    output logic [IW-1:0]   gnt_id_o
);

    typedef logic [WW-1:0] cred_t;

    hpdcache_wrr_arb_st_e state_q, state_d;
    cred_t                credit_q [N];
    cred_t                cred_next [N];
    cred_t                wt_eff [N];
    cred_t                cred_view [N];
    logic [IW-1:0]        ptr_q, ptr_next;
    logic [N-1:0]         gnt_q;
    logic [N-1:0]         has_cred, eligible, pick;
    logic                 refill, refill_commit;
    logic                 hs, xfer_done, beat_last;

`ifdef HPDCACHE_WRR_ARB_BURST_LOCK_EN
    assign beat_last = last_i;
`else
    assign beat_last = 1'b1;
`endif

    // Refill view: if nobody requesting has credit, everybody reads as weight.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            wt_eff[i]   = (weight_i[i*WW +: WW] == '0) ? cred_t'(1) : weight_i[i*WW +: WW];
            has_cred[i] = (credit_q[i] != '0);
        end
        refill = (|req_i) && !(|(req_i & has_cred));
        for (int i = 0; i < N; i++) begin
            cred_view[i] = refill ? wt_eff[i] : credit_q[i];
            eligible[i]  = req_i[i] && (cred_view[i] != '0);
        end
    end

    hpdcache_rr_pick #(.N(N)) u_pick (
        .vec_i    (eligible),
        .ptr_i    (ptr_q),
        .onehot_o (pick)
    );

    // Grant FSM. gnt_o is forced low during reset so a HOLD grant vanishes
    // in the same cycle reset is asserted.
    always_comb begin
        state_d = state_q;
        gnt_o   = '0;
        unique case (state_q)
            IDLE: begin
                gnt_o = pick;
                if (|pick) begin
                    if (!ready_i)        state_d = HOLD;
                    else if (!beat_last) state_d = LOCK;
                end
            end
            HOLD: begin
                gnt_o = gnt_q;
                if (ready_i) state_d = beat_last ? IDLE : LOCK;
            end
            LOCK: begin
                gnt_o = gnt_q;
                if (ready_i && beat_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) gnt_o = '0;
    end

    assign gnt_valid_o = |gnt_o;
    assign hs          = gnt_valid_o && ready_i;
    assign xfer_done   = hs && beat_last;
    // Reload is committed when the grant is first issued, so a later HOLD or
    // LOCK completion can decrement from a credit that is already >= 1.
    assign refill_commit = (state_q == IDLE) && (|pick) && refill;

    always_comb begin
        gnt_id_o = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_o[i]) gnt_id_o = gnt_id_o | IW'(i);
        end
    end

    always_comb begin
        ptr_next = ptr_q;
        for (int i = 0; i < N; i++) begin
            cred_next[i] = refill_commit ? wt_eff[i] : credit_q[i];
        end
        for (int i = 0; i < N; i++) begin
            if (xfer_done && gnt_o[i]) begin
                cred_next[i] = cred_next[i] - cred_t'(1);
                if (cred_next[i] != '0) ptr_next = IW'(i);
                else                    ptr_next = (i == N-1) ? '0 : IW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < N; i++) credit_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) gnt_q <= pick;
            ptr_q   <= ptr_next;
            for (int i = 0; i < N; i++) credit_q[i] <= cred_next[i];
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(gnt_o));
    a_gnt_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (gnt_valid_o && !ready_i) |=> (gnt_o == $past(gnt_o)));
    a_hold_no_withdraw: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == HOLD) |-> (|(req_i & gnt_q)));

endmodule
